// File: rtl/ahb_lite_sram_responder.sv
// AHB-Lite responder backed by a word-organised SRAM array.
// Supports byte/half/word accesses, programmable wait states and the two-cycle ERROR response.
module ahb_lite_sram_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [3:0]            HPROT,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    localparam int          IDX_W = $clog2(MEM_WORDS);
    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              cnt;
    logic [3:0]              cnt_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    write_q;
    logic                    active_q;
    logic [31:0]             mem [MEM_WORDS];
    logic                    open;
    logic                    accept;
    logic                    illegal;
    logic                    complete;
    logic                    wr_en;
    logic [3:0]              be;
    logic [IDX_W-1:0]        idx;
    logic                    unused_bits;

    assign open    = (state == S_IDLE) || (state == S_ERR2);
    assign accept  = open && HSEL && HREADY && HTRANS[1];
    assign illegal = (32'(HADDR) >= LIMIT)
                  || HSIZE[2]
                  || (HSIZE[1:0] == 2'b11)
                  || ((HSIZE == 3'b001) && HADDR[0])
                  || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));

    // A legal data phase finishes in the IDLE state (directly or after WAIT drains)
    assign complete = (state == S_IDLE) && active_q;
    assign wr_en    = complete && write_q;
    assign idx      = addr_q[IDX_W+1:2];
    assign HRDATA   = (complete && !write_q) ? mem[idx] : 32'h0;

    assign unused_bits = ^{HPROT, HTRANS[0], addr_q[ADDR_WIDTH-1:IDX_W+2]};

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 4'd0) state_nxt = S_IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = S_ERR2;
            end
            S_ERR2:  HRESP = 1'b1;
            default: ;
        endcase
        if (open) begin
            state_nxt = S_IDLE;
            if (accept && illegal) begin
                state_nxt = S_ERR1;
            end else if (accept && (WAIT_STATES > 0)) begin
                state_nxt = S_WAIT;
                cnt_nxt   = 4'(WAIT_STATES - 1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            size_q   <= 2'b00;
            write_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q  <= HADDR;
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
            if (open) active_q <= accept && !illegal;
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

endmodule
